jtkiwi_colmix: RTL and testbench

JTKIWI_COLMIX -- requirements
Module: jtkiwi_colmix

---
 rtl/jtkiwi_pkg.sv | 16 +
 rtl/jtframe_dual_ram16.sv | 23 ++
 rtl/jtkiwi_colmix.sv | 78 +++++++
 tb/tb_jtkiwi_colmix.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jtkiwi_pkg.sv
// jtkiwi_pkg: pixel field widths and palette word layout shared by jtkiwi_gfx and jtkiwi_colmix
package jtkiwi_pkg;
  localparam int PAL_W         = 5;
  localparam int COL_W         = 4;
  localparam int PXL_W         = PAL_W + COL_W;
  localparam int BLANK_DLY_DEF = 2;
  typedef struct packed {
    logic       x;
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } pal_word_t;
  function automatic logic opaque(input logic [PXL_W-1:0] p);
    return p[COL_W-1:0] != '0;
  endfunction
endpackage

// File: rtl/jtframe_dual_ram16.sv
// jtframe_dual_ram16: 16-bit true dual-port RAM; port 0 read/write with byte enables, port 1 read-only; registered reads
//   clk     : clock
//   addr0_i : port 0 address     data0_i : write data     we0_i : byte write enables     q0_o : port 0 read data
//   addr1_i : port 1 address     q1_o    : port 1 read data
module jtframe_dual_ram16 #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0_i,
  input  logic [15:0]   data0_i,
  input  logic [1:0]    we0_i,
  output logic [15:0]   q0_o,
  input  logic [AW-1:0] addr1_i,
  output logic [15:0]   q1_o
);
  logic [15:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we0_i[0]) mem[addr0_i][7:0]  <= data0_i[7:0];
    if (we0_i[1]) mem[addr0_i][15:8] <= data0_i[15:8];
    q0_o <= mem[addr0_i];
    q1_o <= mem[addr1_i];
  end
endmodule

// File: rtl/jtkiwi_colmix.sv
// jtkiwi_colmix: layer priority mux, palette lookup and blank alignment for the video output
//   rst, clk, pxl_cen        : async reset, clock, pixel enable
//   LHBL, LVBL               : active-low blanking in; LHBL_dly, LVBL_dly aligned copies out
//   scr_pxl, obj_pxl, gfx_en : layer pixels {pal,col} and layer enables (bit0 scroll, bit1 object)
//   cpu_addr, cpu_dout, cpu_rnw, pal_cs, cpu_din : CPU palette port (cpu_addr[10] selects the byte)
//   red, green, blue         : 5-bit colour out, black while blanked
module jtkiwi_colmix
  import jtkiwi_pkg::*;
#(
  parameter int BLANK_DLY = BLANK_DLY_DEF
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             pxl_cen,
  input  logic             LHBL,
  input  logic             LVBL,
  input  logic [PXL_W-1:0] scr_pxl,
  input  logic [PXL_W-1:0] obj_pxl,
  input  logic [10:0]      cpu_addr,
  input  logic [7:0]       cpu_dout,
  input  logic             cpu_rnw,
  input  logic             pal_cs,
  output logic [7:0]       cpu_din,
  input  logic [1:0]       gfx_en,
  output logic [4:0]       red,
  output logic [4:0]       green,
  output logic [4:0]       blue,
  output logic             LHBL_dly,
  output logic             LVBL_dly
);
  logic [PXL_W-1:0]     pal_addr_q, pal_addr_d;
  logic [15:0]          cpu_q, vid_q;
  pal_word_t            vid_w;
  logic [14:0]          rgb_q;
  logic [BLANK_DLY-1:0] hb_q, vb_q;
  logic                 sel_q, cs_q;
  logic                 unused_bits;
  // The video port is addressed with the next stage-1 value so its registered
  // read already holds the selected entry at the following pxl_cen, whatever
  // the pxl_cen duty cycle.
  always_comb pal_addr_d = !pxl_cen ? pal_addr_q :
                           gfx_en[1] && opaque(obj_pxl) ? obj_pxl :
                           gfx_en[0] ? scr_pxl : '0;
  jtframe_dual_ram16 #(.AW(PXL_W)) u_ram (
    .clk    (clk),
    .addr0_i(cpu_addr[PXL_W-1:0]),
    .data0_i({2{cpu_dout}}),
    .we0_i  ({2{pal_cs & ~cpu_rnw}} & {cpu_addr[10], ~cpu_addr[10]}),
    .q0_o   (cpu_q),
    .addr1_i(pal_addr_d),
    .q1_o   (vid_q)
  );
  assign vid_w       = vid_q;
  assign unused_bits = ^{vid_w.x, cpu_addr[9]};
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      pal_addr_q <= '0;
      rgb_q      <= '0;
      hb_q       <= '0;
      vb_q       <= '0;
      sel_q      <= 1'b0;
      cs_q       <= 1'b0;
    end else begin
      pal_addr_q <= pal_addr_d;
      sel_q      <= cpu_addr[10];
      cs_q       <= pal_cs;
      if (pxl_cen) begin
        rgb_q <= {vid_w.r, vid_w.g, vid_w.b};
        hb_q  <= BLANK_DLY'({hb_q, LHBL});
        vb_q  <= BLANK_DLY'({vb_q, LVBL});
      end
    end
  end
  assign cpu_din  = cs_q ? (sel_q ? cpu_q[15:8] : cpu_q[7:0]) : '0;
  assign LHBL_dly = hb_q[BLANK_DLY-1];
  assign LVBL_dly = vb_q[BLANK_DLY-1];
  assign {red, green, blue} = LHBL_dly && LVBL_dly ? rgb_q : '0;
endmodule

// File: tb/tb_jtkiwi_colmix.sv
// tb_jtkiwi_colmix: self-checking bench for jtkiwi_colmix against a palette-array reference model
module tb_jtkiwi_colmix;
  logic        clk = 0, rst = 0, pxl_cen = 0, LHBL = 0, LVBL = 0;
  logic [8:0]  scr_pxl = 0, obj_pxl = 0;
  logic [10:0] cpu_addr = 0;
  logic [7:0]  cpu_dout = 0, cpu_din;
  logic        cpu_rnw = 1, pal_cs = 0;
  logic [1:0]  gfx_en = 0;
  logic [4:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;
  wire  [14:0] rgb = {red, green, blue};
  int          vecs = 0, errs = 0;
  logic [15:0] pal_m [512];
  logic [14:0] exp_c, prv_c, cen_rgb;
  logic        exp_h, exp_v, prv_h, prv_v, cen_h, cen_v;

  jtkiwi_colmix #(.BLANK_DLY(2)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .pal_cs(pal_cs), .cpu_din(cpu_din), .gfx_en(gfx_en),
    .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic cen);
    pxl_cen = cen;
    @(posedge clk);
    #1;
  endtask

  task automatic mwr(input logic [10:0] wa, input logic [7:0] wd);
    if (wa[10]) pal_m[wa[8:0]][15:8] = wd;
    else        pal_m[wa[8:0]][7:0]  = wd;
  endtask

  task automatic cpu_wr(input logic [10:0] wa, input logic [7:0] wd);
    pal_cs = 1; cpu_rnw = 0; cpu_addr = wa; cpu_dout = wd;
    mwr(wa, wd);
    tick(0);
    pal_cs = 0; cpu_rnw = 1;
  endtask

  task automatic set_pal(input logic [8:0] e, input logic [15:0] w);
    cpu_wr({2'b00, e}, w[7:0]);
    cpu_wr({2'b10, e}, w[15:8]);
  endtask

  // One pixel period: pxl_cen clock then an idle clock. The model's expected
  // output after this pixel's enable is the previous pixel's colour.
  task automatic pixel(input logic [8:0] obj, scr, input logic [1:0] gfx, input logic lh, lv,
                       input logic wr, input logic [10:0] wa, input logic [7:0] wd);
    logic [8:0]  a;
    logic [14:0] c;
    obj_pxl = obj; scr_pxl = scr; gfx_en = gfx; LHBL = lh; LVBL = lv;
    if (wr) begin
      pal_cs = 1; cpu_rnw = 0; cpu_addr = wa; cpu_dout = wd;
      mwr(wa, wd);
    end
    a = (gfx[1] && obj[3:0] != 0) ? obj : gfx[0] ? scr : 9'h000;
    c = (lh && lv) ? pal_m[a][14:0] : 15'h0;
    tick(1);
    pal_cs = 0; cpu_rnw = 1;
    cen_rgb = rgb; cen_h = LHBL_dly; cen_v = LVBL_dly;
    exp_c = prv_c; exp_h = prv_h; exp_v = prv_v;
    prv_c = c; prv_h = lh; prv_v = lv;
    tick(0);
  endtask

  task automatic show(input logic [8:0] obj, scr, input logic [1:0] gfx);
    pixel(obj, scr, gfx, 1, 1, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst = 1;
    tick(1); tick(0);
    vecs++; if (rgb !== 15'h0) begin errs++; $display("FAIL reset_rgb got=%h want=0", rgb); end
    vecs++; if ({LHBL_dly, LVBL_dly} !== 2'b00) begin errs++; $display("FAIL reset_blank got=%b want=00", {LHBL_dly, LVBL_dly}); end
    vecs++; if (cpu_din !== 8'h00) begin errs++; $display("FAIL reset_din got=%h want=00", cpu_din); end
    rst = 0;
    prv_c = 0; prv_h = 0; prv_v = 0;
  endtask

  task automatic test_cpu_readback;
    for (int e = 0; e < 512; e++) set_pal(e[8:0], 16'($urandom));
    for (int i = 0; i < 8; i++) begin
      logic [8:0] e;
      logic       hb;
      logic [7:0] want;
      e = 9'($urandom); hb = 1'($urandom);
      want = hb ? pal_m[e][15:8] : pal_m[e][7:0];
      pal_cs = 1; cpu_rnw = 1; cpu_addr = {hb, 1'b0, e};
      tick(0);
      vecs++; if (cpu_din !== want) begin errs++; $display("FAIL readback e=%h got=%h want=%h", e, cpu_din, want); end
      pal_cs = 0;
      tick(0);
      vecs++; if (cpu_din !== 8'h00) begin errs++; $display("FAIL din_idle got=%h want=00", cpu_din); end
    end
  endtask

  task automatic test_basic;
    set_pal(9'h012, 16'h7FFF);
    show(9'h000, 9'h012, 3);
    show(9'h000, 9'h012, 3);
    vecs++; if (rgb !== 15'h7FFF || rgb !== exp_c) begin errs++; $display("FAIL basic_white got=%h want=7fff", rgb); end
  endtask

  task automatic test_priority;
    set_pal(9'h105, 16'h001F);
    set_pal(9'h012, 16'h7C00);
    show(9'h105, 9'h012, 3);
    show(9'h105, 9'h012, 3);
    vecs++; if (rgb !== 15'h001F) begin errs++; $display("FAIL obj_priority got=%h want=001f", rgb); end
    show(9'h105, 9'h012, 1);
    show(9'h105, 9'h012, 1);
    vecs++; if (rgb !== 15'h7C00) begin errs++; $display("FAIL obj_disabled got=%h want=7c00", rgb); end
    show(9'h100, 9'h012, 3);
    show(9'h100, 9'h012, 3);
    vecs++; if (rgb !== 15'h7C00) begin errs++; $display("FAIL obj_transparent got=%h want=7c00", rgb); end
    show(9'h100, 9'h012, 0);
    show(9'h100, 9'h012, 0);
    vecs++; if (rgb !== pal_m[0][14:0]) begin errs++; $display("FAIL all_disabled got=%h want=%h", rgb, pal_m[0][14:0]); end
  endtask

  task automatic test_blank;
    logic lh_seq [6] = '{1, 1, 0, 1, 1, 1};
    set_pal(9'h021, 16'h2A55);
    for (int i = 0; i < 6; i++) begin
      pixel(9'h000, 9'h021, 1, lh_seq[i], 1, 0, 0, 0);
      vecs++; if (LHBL_dly !== exp_h || cen_h !== exp_h) begin errs++; $display("FAIL blank_dly i=%0d got=%b/%b want=%b", i, cen_h, LHBL_dly, exp_h); end
      vecs++; if (rgb !== exp_c) begin errs++; $display("FAIL blank_rgb i=%0d got=%h want=%h", i, rgb, exp_c); end
      if (i == 3) begin
        vecs++; if (LHBL_dly !== 1'b0 || rgb !== 15'h0) begin errs++; $display("FAIL blank_two_cen got=%b,%h want=0,0", LHBL_dly, rgb); end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      pixel(9'($urandom), 9'($urandom), 2'($urandom), ($urandom % 8) != 0, ($urandom % 16) != 0, 0, 0, 0);
      vecs++; if (cen_rgb !== exp_c || rgb !== exp_c) begin errs++; $display("FAIL rand_rgb i=%0d got=%h/%h want=%h", i, cen_rgb, rgb, exp_c); end
      vecs++; if ({cen_h, cen_v, LHBL_dly, LVBL_dly} !== {exp_h, exp_v, exp_h, exp_v}) begin
        errs++; $display("FAIL rand_blank i=%0d got=%b%b want=%b%b", i, LHBL_dly, LVBL_dly, exp_h, exp_v);
      end
    end
  endtask

  task automatic test_dual_port;
    logic [14:0] old_c;
    set_pal(9'h033, 16'h1234);
    old_c = 15'h1234;
    show(9'h000, 9'h033, 1);
    pixel(9'h000, 9'h033, 1, 1, 1, 1, {2'b10, 9'h033}, 8'h55);
    vecs++; if (rgb !== old_c || rgb !== exp_c) begin errs++; $display("FAIL same_cycle_old got=%h want=%h", rgb, old_c); end
    show(9'h000, 9'h033, 1);
    vecs++; if (rgb !== 15'h5534) begin errs++; $display("FAIL next_pixel_new got=%h want=5534", rgb); end
    pal_cs = 1; cpu_rnw = 1; cpu_addr = {2'b10, 9'h033};
    tick(0);
    vecs++; if (cpu_din !== 8'h55) begin errs++; $display("FAIL dp_readback got=%h want=55", cpu_din); end
    pal_cs = 0;
    tick(0);
  endtask

  task automatic test_reset_mid;
    set_pal(9'h044, 16'h7FFF);
    show(9'h000, 9'h044, 1);
    show(9'h000, 9'h044, 1);
    vecs++; if (rgb !== 15'h7FFF) begin errs++; $display("FAIL pre_reset got=%h want=7fff", rgb); end
    #2 rst = 1;
    #1;
    vecs++; if ({rgb, LHBL_dly, LVBL_dly, cpu_din} !== 25'h0) begin
      errs++; $display("FAIL async_reset got=%h,%b,%b,%h want=0", rgb, LHBL_dly, LVBL_dly, cpu_din);
    end
    tick(0);
    rst = 0;
    prv_c = 0; prv_h = 0; prv_v = 0;
    show(9'h000, 9'h044, 1);
    vecs++; if (rgb !== 15'h0 || LHBL_dly !== 1'b0 || rgb !== exp_c) begin errs++; $display("FAIL post_reset_black got=%h,%b want=0,0", rgb, LHBL_dly); end
    show(9'h000, 9'h044, 1);
    vecs++; if (rgb !== 15'h7FFF || rgb !== exp_c) begin errs++; $display("FAIL post_reset_colour got=%h want=7fff", rgb); end
    for (int i = 0; i < 6; i++) begin
      logic [8:0] e;
      e = (i == 0) ? 9'h044 : 9'($urandom);
      pal_cs = 1; cpu_rnw = 1; cpu_addr = {2'b00, e};
      tick(0);
      vecs++; if (cpu_din !== pal_m[e][7:0]) begin errs++; $display("FAIL kept_lo e=%h got=%h want=%h", e, cpu_din, pal_m[e][7:0]); end
      cpu_addr = {2'b10, e};
      tick(0);
      vecs++; if (cpu_din !== pal_m[e][15:8]) begin errs++; $display("FAIL kept_hi e=%h got=%h want=%h", e, cpu_din, pal_m[e][15:8]); end
      pal_cs = 0;
    end
  endtask

  initial begin
    for (int e = 0; e < 512; e++) pal_m[e] = 16'h0;
    test_reset;
    test_cpu_readback;
    test_basic;
    test_priority;
    test_blank;
    test_random;
    test_dual_port;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
